// File: rtl/mult_pkg.sv
// ============================================================================
// Module      : mult_pkg
// Description : Shared width, state encoding and product type for the
//               sequential shift-add multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mult_pkg;

    localparam int MULT_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mult_state_t;

    typedef logic [2*MULT_WIDTH-1:0] mult_prod_t;

endpackage : mult_pkg

`default_nettype wire

// File: rtl/mult_step.sv
// ============================================================================
// Module      : mult_step
// Description : One shift-add iteration: conditional accumulate, shift the
//               multiplicand left and the multiplier right.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_step
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH
) (
    input  logic [2*WIDTH-1:0] acc_i,
    input  logic [2*WIDTH-1:0] mcand_i,
    input  logic [WIDTH-1:0]   mplier_i,
    output logic [2*WIDTH-1:0] acc_o,
    output logic [2*WIDTH-1:0] mcand_o,
    output logic [WIDTH-1:0]   mplier_o
);

    // The full product fits in 2*WIDTH bits, so the add can never carry out.
    assign acc_o    = mplier_i[0] ? (acc_i + mcand_i) : acc_i;
    assign mcand_o  = mcand_i << 1;
    assign mplier_o = mplier_i >> 1;

endmodule : mult_step

`default_nettype wire

// File: rtl/multiplier_32_seq.sv
// ============================================================================
// Module      : multiplier_32_seq
// Description : Sequential unsigned shift-add multiplier with valid/ready
//               handshakes; one partial product per cycle, 2*WIDTH result.
//               Optional macro MULT_EARLY_EXIT_EN ends iteration once the
//               remaining multiplier bits are all zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module multiplier_32_seq
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    mult_state_t        state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] mcand_q, mcand_d;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_mcand_next;
    logic [WIDTH-1:0]   w_mplier_next;
    logic               w_last;

    mult_step #(
        .WIDTH    (WIDTH)
    ) u_step (
        .acc_i    (acc_q),
        .mcand_i  (mcand_q),
        .mplier_i (mplier_q),
        .acc_o    (w_acc_next),
        .mcand_o  (w_mcand_next),
        .mplier_o (w_mplier_next)
    );

`ifdef MULT_EARLY_EXIT_EN
    // Once no set multiplier bits remain, further iterations add nothing.
    assign w_last = (count_q == CNT_W'(WIDTH - 1)) || (w_mplier_next == '0);
`else
    assign w_last = (count_q == CNT_W'(WIDTH - 1));
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            count_q  <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d  = BUSY;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, a};
                    mplier_d = b;
                    count_d  = '0;
                end
            end
            BUSY: begin
                acc_d    = w_acc_next;
                mcand_d  = w_mcand_next;
                mplier_d = w_mplier_next;
                count_d  = count_q + CNT_W'(1);
                if (w_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // The accumulator is only written on accept and in BUSY, so it holds the
    // finished product unchanged for the whole DONE phase.
    assign product   = acc_q;
    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q == BUSY);

endmodule : multiplier_32_seq

`default_nettype wire

// File: tb/tb_multiplier_32_seq.sv
// ============================================================================
// Module      : tb_multiplier_32_seq
// Description : Directed and randomized self-checking bench for the
//               sequential multiplier.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_multiplier_32_seq;

    localparam int W = 32;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [2*W-1:0] product;
    logic           busy;

    int n_checks = 0;
    int n_fail   = 0;

    multiplier_32_seq dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic int exp_lat(input logic [W-1:0] bv);
        int n;
        n = 0;
`ifdef MULT_EARLY_EXIT_EN
        for (int i = 0; i < W; i++) if (bv[i]) n = i + 1;
        if (n == 0) n = 1;
        return n + 1;
`else
        n = bv[0] ? W + 1 : W + 1;
        return n;
`endif
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents operands for one cycle, scrambles them afterwards, and counts
    // cycles until out_valid (bounded; a timeout yields a wrong latency).
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, output int lat);
        a = av;
        b = bv;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        lat = 1;
        while (!out_valid && lat < 200) begin
            tick();
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL reset: in_ready=%b out_valid=%b busy=%b product=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int lat;
        out_ready = 1'b1;
        run_op(32'd6, 32'd7, lat);
        n_checks++;
        if (lat !== exp_lat(32'd7)) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d want %0d", lat, exp_lat(32'd7));
        end
        n_checks++;
        if (product !== 64'd42) begin
            n_fail++;
            $display("FAIL basic_product: got %0d want 42", product);
        end
        tick();
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_release: in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_max();
        int lat;
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
        n_checks++;
        if (product !== 64'hFFFF_FFFE_0000_0001 || lat !== exp_lat(32'hFFFF_FFFF)) begin
            n_fail++;
            $display("FAIL max_operands: product=%h lat=%0d want fffffffe00000001 lat=%0d",
                     product, lat, exp_lat(32'hFFFF_FFFF));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_zero();
        int lat;
        run_op(32'd123, 32'd0, lat);
        n_checks++;
        if (product !== 64'd0 || lat !== exp_lat(32'd0)) begin
            n_fail++;
            $display("FAIL zero_b: product=%h lat=%0d want 0 lat=%0d", product, lat, exp_lat(32'd0));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        run_op(32'd0, 32'hDEAD_BEEF, lat);
        n_checks++;
        if (product !== 64'd0 || lat !== exp_lat(32'hDEAD_BEEF)) begin
            n_fail++;
            $display("FAIL zero_a: product=%h lat=%0d want 0 lat=%0d", product, lat, exp_lat(32'hDEAD_BEEF));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        run_op(32'd100, 32'd200, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            a = 32'd1;
            b = 32'd1;
            tick();
            n_checks++;
            if (product !== 64'd20000 || out_valid !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL hold_done[%0d]: product=%0d out_valid=%b in_ready=%b busy=%b want 20000 1 0 0",
                         i, product, out_valid, in_ready, busy);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL hold_release: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        run_op(32'd9, 32'd9, lat);
        n_checks++;
        if (product !== 64'd81 || lat !== exp_lat(32'd9)) begin
            n_fail++;
            $display("FAIL back_to_back: product=%0d lat=%0d want 81 lat=%0d", product, lat, exp_lat(32'd9));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int lat;
        a = 32'd1000;
        b = 32'd1000;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        n_checks++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_busy: busy=%b want 1", busy);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || product !== '0) begin
            n_fail++;
            $display("FAIL mid_reset: in_ready=%b out_valid=%b busy=%b product=%h want 1 0 0 0",
                     in_ready, out_valid, busy, product);
        end
        run_op(32'd3, 32'd5, lat);
        n_checks++;
        if (product !== 64'd15 || lat !== exp_lat(32'd5)) begin
            n_fail++;
            $display("FAIL after_reset: product=%0d lat=%0d want 15 lat=%0d", product, lat, exp_lat(32'd5));
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_random();
        int             lat;
        int             waits;
        logic [W-1:0]   ra, rb;
        logic [2*W-1:0] expd;
        for (int n = 0; n < 1000; n++) begin
            ra = $urandom;
            rb = (n % 10 == 0) ? 32'd0 : ((n % 7 == 0) ? W'($urandom_range(1, 255)) : W'($urandom));
            expd = {32'd0, ra} * {32'd0, rb};
            run_op(ra, rb, lat);
            n_checks++;
            if (product !== expd || lat !== exp_lat(rb)) begin
                n_fail++;
                $display("FAIL rand[%0d]: a=%h b=%h product=%h lat=%0d want %h lat=%0d",
                         n, ra, rb, product, lat, expd, exp_lat(rb));
            end
            if (rb != 0) begin
                n_checks++;
                if ((product / {32'd0, rb}) !== {32'd0, ra} || (product % {32'd0, rb}) !== 64'd0) begin
                    n_fail++;
                    $display("FAIL round_trip[%0d]: q=%h rem=%h want q=%h rem=0",
                             n, product / {32'd0, rb}, product % {32'd0, rb}, ra);
                end
            end
            waits = $urandom_range(0, 3);
            for (int w = 0; w < waits; w++) begin
                tick();
                n_checks++;
                if (product !== expd || out_valid !== 1'b1) begin
                    n_fail++;
                    $display("FAIL rand_hold[%0d]: product=%h out_valid=%b want %h 1", n, product, out_valid, expd);
                end
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_max();
        test_zero();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule : tb_multiplier_32_seq

`default_nettype wire
